// File: rtl/cond_logic_if.sv
// Decoder-to-conditional-stage bundle: decoder requests, condition field and ALU flags in,
// gated write/branch enables and the registered NZCV flags out.
interface cond_logic_if;
  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  modport master (
    output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  modport slave (
    input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );
endinterface

// File: rtl/cond_logic.sv
// ARM conditional-execution stage: holds NZCV and gates PCSrc/RegWrite/MemWrite by the condition.
// Outputs are combinational from Cond and the registered flags; flag updates land one edge later.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic          clk,
  input  logic          reset,
  cond_logic_if.slave   bus
);

  logic [3:0]  flags_q;
  logic [3:0]  flags_d;
  logic [15:0] cond_tbl;
  logic        cond_ex;
  logic        n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Per-code pass table indexed by Cond, so an X on Cond propagates rather than being masked.
  always_comb begin
    cond_tbl      = '0;
    cond_tbl[0]   = z_f;
    cond_tbl[1]   = ~z_f;
    cond_tbl[2]   = c_f;
    cond_tbl[3]   = ~c_f;
    cond_tbl[4]   = n_f;
    cond_tbl[5]   = ~n_f;
    cond_tbl[6]   = v_f;
    cond_tbl[7]   = ~v_f;
    cond_tbl[8]   = c_f & ~z_f;
    cond_tbl[9]   = ~c_f | z_f;
    cond_tbl[10]  = (n_f == v_f);
    cond_tbl[11]  = (n_f != v_f);
    cond_tbl[12]  = ~z_f & (n_f == v_f);
    cond_tbl[13]  = z_f | (n_f != v_f);
    cond_tbl[14]  = 1'b1;
    cond_tbl[15]  = 1'b0;
  end

  assign cond_ex = cond_tbl[bus.Cond];

  always_comb begin
    flags_d = flags_q;
    if (bus.en && cond_ex && bus.FlagW[1]) begin
      flags_d[3:2] = bus.ALUFlags[3:2];
    end
    if (bus.en && cond_ex && bus.FlagW[0]) begin
      flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RESET;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS  & cond_ex;
  assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & cond_ex;
  assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: hand-computed expectations for gating, flag updates and condition codes.
module tb_cond_logic;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  cond_logic_if bus ();

  cond_logic #(.FLAG_RESET(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] flagw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic nowrite, input logic en);
    bus.Cond     = cond;
    bus.ALUFlags = alu;
    bus.FlagW    = flagw;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.MemW     = memw;
    bus.NoWrite  = nowrite;
    bus.en       = en;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an arbitrary NZCV value through an always-pass flag-setting instruction.
  task automatic load_flags(input logic [3:0] v);
    drive(4'b1110, v, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic cond_is(input string tag, input logic [3:0] cond, input logic exp);
    drive(cond, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk(tag, {3'b000, bus.CondEx}, {3'b000, exp});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    chk("reset_flags", bus.Flags, 4'b0000);

    // AL passes, EQ fails with Z=0
    drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("al_condex", {3'b0, bus.CondEx}, 4'b0001);
    chk("al_regwrite", {3'b0, bus.RegWrite}, 4'b0001);
    drive(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("eq_fail_condex", {3'b0, bus.CondEx}, 4'b0000);
    chk("eq_fail_regwrite", {3'b0, bus.RegWrite}, 4'b0000);

    // CMP: NoWrite suppresses RegWrite, flags still update, visible next cycle
    drive(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("cmp_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
    chk("cmp_flags_same_cycle", bus.Flags, 4'b0000);
    tick();
    chk("cmp_flags_next", bus.Flags, 4'b0100);
    cond_is("cmp_eq", 4'b0000, 1'b1);
    cond_is("cmp_ne", 4'b0001, 1'b0);

    // Partial updates
    drive(4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("partial_nz", bus.Flags, 4'b1000);
    drive(4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("partial_cv", bus.Flags, 4'b1011);

    // Failed condition blocks flag update and all writes
    load_flags(4'b0000);
    chk("flags_cleared", bus.Flags, 4'b0000);
    drive(4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("fail_pcsrc", {3'b0, bus.PCSrc}, 4'b0000);
    chk("fail_memwrite", {3'b0, bus.MemWrite}, 4'b0000);
    chk("fail_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
    tick();
    chk("fail_flags_hold", bus.Flags, 4'b0000);
    drive(4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("pass_pcsrc", {3'b0, bus.PCSrc}, 4'b0001);
    chk("pass_memwrite", {3'b0, bus.MemWrite}, 4'b0001);
    chk("pass_regwrite", {3'b0, bus.RegWrite}, 4'b0001);

    // Signed compares and single-flag codes
    load_flags(4'b1001);
    cond_is("ge_nv11", 4'b1010, 1'b1);
    cond_is("lt_nv11", 4'b1011, 1'b0);
    cond_is("gt_nv11", 4'b1100, 1'b1);
    cond_is("le_nv11", 4'b1101, 1'b0);
    cond_is("mi_n1", 4'b0100, 1'b1);
    cond_is("pl_n1", 4'b0101, 1'b0);
    cond_is("vs_v1", 4'b0110, 1'b1);
    cond_is("vc_v1", 4'b0111, 1'b0);
    load_flags(4'b1000);
    cond_is("ge_n1v0", 4'b1010, 1'b0);
    cond_is("lt_n1v0", 4'b1011, 1'b1);
    cond_is("gt_n1v0", 4'b1100, 1'b0);
    cond_is("le_n1v0", 4'b1101, 1'b1);
    load_flags(4'b0110);
    cond_is("hi_zc", 4'b1000, 1'b0);
    cond_is("ls_zc", 4'b1001, 1'b1);
    cond_is("eq_z1", 4'b0000, 1'b1);
    cond_is("cs_c1", 4'b0010, 1'b1);
    cond_is("cc_c1", 4'b0011, 1'b0);
    cond_is("nv_never", 4'b1111, 1'b0);
    load_flags(4'b0010);
    cond_is("hi_c1z0", 4'b1000, 1'b1);
    cond_is("ls_c1z0", 4'b1001, 1'b0);
    cond_is("gt_all0ish", 4'b1100, 1'b1);

    // Stall: en=0 holds flags, outputs still combinational
    load_flags(4'b0110);
    drive(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_condex", {3'b0, bus.CondEx}, 4'b0001);
    chk("stall_regwrite", {3'b0, bus.RegWrite}, 4'b0001);
    tick();
    chk("stall_flags_hold", bus.Flags, 4'b0110);

    // Reset overrides a concurrent flag write
    drive(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    chk("midreset_flags", bus.Flags, 4'b0000);
    reset = 1'b0;
    drive(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("post_reset_flags", bus.Flags, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
